// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: 2-entry in-order skid-buffer pipeline register with flush and registered ready.
module pipe_stage_reg #(
    parameter int DATA_W     = 64,
    parameter int CTRL_W     = 8,
    parameter int CLEAR_DATA = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);
    logic [1:0]        cnt, cnt_nxt;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data, skid_data;
    logic              fire_in, fire_out, load_main, load_skid;

    assign count     = cnt;
    assign in_ready  = cnt != 2'd2;
    assign out_valid = cnt != 2'd0;
    assign out_ctrl  = out_valid ? main_ctrl : '0;
    assign out_data  = main_data;

    // When full, main refills from skid; otherwise main takes the input.
    always_comb begin
        fire_in   = in_valid && in_ready;
        fire_out  = out_valid && out_ready;
        load_main = (cnt == 2'd2) ? fire_out : fire_in && (cnt == 2'd0 || fire_out);
        load_skid = fire_in && cnt == 2'd1 && !fire_out;
        cnt_nxt   = cnt + 2'(fire_in) - 2'(fire_out);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            main_ctrl <= '0;
            skid_ctrl <= '0;
            main_data <= '0;
            skid_data <= '0;
        end else if (flush) begin
            cnt       <= '0;
            main_ctrl <= '0;
            skid_ctrl <= '0;
            if (CLEAR_DATA != 0) begin
                main_data <= '0;
                skid_data <= '0;
            end
        end else begin
            cnt <= cnt_nxt;
            if (load_main) begin
                main_ctrl <= (cnt == 2'd2) ? skid_ctrl : in_ctrl;
                main_data <= (cnt == 2'd2) ? skid_data : in_data;
            end
            if (load_skid) begin
                skid_ctrl <= in_ctrl;
                skid_data <= in_data;
            end
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed scenario tests of pipe_stage_reg with hand-computed expectations.
module tb_pipe_stage_reg;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [7:0]  in_ctrl = '0, out_ctrl;
    logic [63:0] in_data = '0, out_data;
    logic [1:0]  count;

    logic        b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic        b_in_ready, b_out_valid;
    logic [7:0]  b_in_ctrl = '0, b_out_ctrl;
    logic [31:0] b_in_data = '0, b_out_data;
    logic [1:0]  b_count;

    int errs = 0;
    int checks = 0;

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .CLEAR_DATA(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data), .count(count)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .CLEAR_DATA(0)) dut_hold (
        .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_ctrl(b_in_ctrl), .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_ctrl(b_out_ctrl), .out_data(b_out_data), .count(b_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (count !== 2'd0) begin errs++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_ctrl !== 8'h00) begin errs++; $display("FAIL reset_ctrl got=%h exp=00", out_ctrl); end
        checks++; if (out_data !== 64'h0) begin errs++; $display("FAIL reset_data got=%h exp=0", out_data); end
        checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        checks++; if (b_out_data !== 32'h0) begin errs++; $display("FAIL reset_hold_data got=%h exp=0", b_out_data); end
        #2 rst = 1'b0;
        step();
    endtask

    task automatic test_stream();
        logic [63:0] d [4] = '{64'hD1, 64'hD2, 64'hD3, 64'hD4};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = d[i];
            in_ctrl = 8'(i + 1);
            step();
            checks++; if (out_data !== d[i]) begin errs++; $display("FAIL stream_data%0d got=%h exp=%h", i, out_data, d[i]); end
            checks++; if (out_ctrl !== 8'(i + 1)) begin errs++; $display("FAIL stream_ctrl%0d got=%h exp=%h", i, out_ctrl, 8'(i + 1)); end
            checks++; if (out_valid !== 1'b1 || count !== 2'd1) begin errs++; $display("FAIL stream_occ%0d got=%b/%0d exp=1/1", i, out_valid, count); end
        end
        in_valid = 1'b0;
        in_data  = 64'hDEAD;
        step();
        checks++; if (count !== 2'd0 || out_ctrl !== 8'h00) begin errs++; $display("FAIL stream_drain got=%0d/%h exp=0/00", count, out_ctrl); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hB1; in_ctrl = 8'h11;
        step();
        in_data   = 64'hB2; in_ctrl = 8'h22;
        step();
        checks++; if (count !== 2'd2 || in_ready !== 1'b0) begin errs++; $display("FAIL bp_full got=%0d/%b exp=2/0", count, in_ready); end
        in_data   = 64'hB3; in_ctrl = 8'h33;
        step();
        checks++; if (count !== 2'd2 || out_data !== 64'hB1) begin errs++; $display("FAIL bp_hold got=%0d/%h exp=2/b1", count, out_data); end
        out_ready = 1'b1;
        step();
        checks++; if (out_data !== 64'hB2 || in_ready !== 1'b1 || count !== 2'd1) begin errs++; $display("FAIL bp_first got=%h/%b/%0d exp=b2/1/1", out_data, in_ready, count); end
        step();
        checks++; if (out_data !== 64'hB3 || out_ctrl !== 8'h33 || count !== 2'd1) begin errs++; $display("FAIL bp_second got=%h/%h/%0d exp=b3/33/1", out_data, out_ctrl, count); end
        in_valid = 1'b0;
        step();
        checks++; if (count !== 2'd0) begin errs++; $display("FAIL bp_drain got=%0d exp=0", count); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 8'hFF;
        in_data   = 64'hF1;
        step();
        in_data   = 64'hF2;
        step();
        checks++; if (count !== 2'd2) begin errs++; $display("FAIL flush_fill got=%0d exp=2", count); end
        flush   = 1'b1;
        in_ctrl = 8'hAA;
        in_data = 64'hAA;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin errs++; $display("FAIL flush_occ got=%0d/%b exp=0/0", count, out_valid); end
        checks++; if (out_ctrl !== 8'h00 || out_data !== 64'h0) begin errs++; $display("FAIL flush_clear got=%h/%h exp=00/0", out_ctrl, out_data); end
        checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || out_ctrl === 8'hAA) begin errs++; $display("FAIL flush_drop got=%b/%h exp=0/00", out_valid, out_ctrl); end
    endtask

    task automatic test_hold_data();
        b_in_valid = 1'b1;
        b_in_ctrl  = 8'h55;
        b_in_data  = 32'h1234;
        step();
        b_in_valid = 1'b0;
        checks++; if (b_out_data !== 32'h1234 || b_out_ctrl !== 8'h55) begin errs++; $display("FAIL hold_load got=%h/%h exp=1234/55", b_out_data, b_out_ctrl); end
        b_flush = 1'b1;
        step();
        b_flush = 1'b0;
        checks++; if (b_out_data !== 32'h1234) begin errs++; $display("FAIL hold_data got=%h exp=1234", b_out_data); end
        checks++; if (b_out_ctrl !== 8'h00 || b_out_valid !== 1'b0 || b_count !== 2'd0) begin errs++; $display("FAIL hold_flush got=%h/%b/%0d exp=00/0/0", b_out_ctrl, b_out_valid, b_count); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 8'h03;
        in_data   = 64'hC1;
        step();
        in_data   = 64'hC2;
        step();
        in_valid  = 1'b0;
        checks++; if (count !== 2'd2) begin errs++; $display("FAIL arst_fill got=%0d exp=2", count); end
        #2 rst = 1'b1;
        #1;
        checks++; if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errs++; $display("FAIL arst_state got=%0d/%b/%b exp=0/0/1", count, out_valid, in_ready); end
        checks++; if (out_ctrl !== 8'h00 || out_data !== 64'h0) begin errs++; $display("FAIL arst_out got=%h/%h exp=00/0", out_ctrl, out_data); end
        #1 rst = 1'b0;
        in_valid = 1'b1;
        in_ctrl  = 8'h05;
        in_data  = 64'hD5;
        step();
        in_valid = 1'b0;
        checks++; if (out_data !== 64'hD5 || out_ctrl !== 8'h05 || count !== 2'd1) begin errs++; $display("FAIL arst_d5 got=%h/%h/%0d exp=d5/05/1", out_data, out_ctrl, count); end
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 8'h01;
        in_data   = 64'hE1;
        step();
        checks++; if (out_data !== 64'hE1 || count !== 2'd1) begin errs++; $display("FAIL simul_load got=%h/%0d exp=e1/1", out_data, count); end
        out_ready = 1'b1;
        in_ctrl   = 8'h02;
        in_data   = 64'hE2;
        step();
        in_valid = 1'b0;
        checks++; if (out_data !== 64'hE2 || out_ctrl !== 8'h02 || count !== 2'd1) begin errs++; $display("FAIL simul_both got=%h/%h/%0d exp=e2/02/1", out_data, out_ctrl, count); end
        step();
        checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin errs++; $display("FAIL simul_drain got=%0d/%b exp=0/0", count, out_valid); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_hold_data();
        test_async_reset();
        test_simultaneous();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
